fp_addsub_seq: RTL and testbench

//   Parametrised multi-cycle IEEE-754 add/subtract unit. Next generation of the single-precision FSM adder.

---
 rtl/fp_addsub_seq_if.sv | 28 ++
 rtl/fp_addsub_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// Handshake bundle for fp_addsub_seq: operand issue side and result side.
// The master drives operands and accepts results, and the slave is the arithmetic unit.
interface fp_addsub_seq_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/subtract unit with round-to-nearest-even and exception flags.
// Operands are captured in IDLE. Specials resolve in CHECK, and finite operands go through
// align, add, normalise and round before the result is held in OUT until it is taken.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic           clk,
   input  logic           reset,
   fp_addsub_seq_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int XW = MAN_W + 4;
   localparam int EW = EXP_W + 2;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CHECK = 3'd1;
   localparam logic [2:0] ALIGN = 3'd2;
   localparam logic [2:0] ADD   = 3'd3;
   localparam logic [2:0] NORM  = 3'd4;
   localparam logic [2:0] ROUND = 3'd5;
   localparam logic [2:0] OUT   = 3'd6;

   localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [EW-1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};
   localparam logic signed [EW-1:0] ONE      = EW'(1);

   logic [2:0]             state;
   logic                   sa, sb;
   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       fa, fb;
   logic                   xs, eff_sub;
   logic signed [EW-1:0]   xe;
   logic [XW-1:0]          xm, ym;
   logic [W-1:0]           res_r;
   logic [3:0]             flg_r;

   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic                   spec_hit;
   logic [W-1:0]           spec_res;
   logic [3:0]             spec_flg;
   logic                   a_bigger, big_s, sticky;
   logic [EXP_W-1:0]       big_e, sml_e, diff;
   logic [MAN_W-1:0]       big_f, sml_f;
   logic [XW-1:0]          sml_m, al_m;
   logic [XW:0]            add_sum;
   logic                   rnd_inc, inexact;
   logic [MAN_W+1:0]       rnd_sum;
   logic [MAN_W:0]         rnd_m;
   logic signed [EW-1:0]   rnd_e;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == OUT);
   assign bus.result    = res_r;
   assign bus.flags     = flg_r;

   // Classify captured operands (denormals count as zero) and pick the special-case answer.
   always_comb begin
      a_zero   = (ea == '0);
      b_zero   = (eb == '0);
      a_inf    = (ea == {EXP_W{1'b1}}) && (fa == '0);
      b_inf    = (eb == {EXP_W{1'b1}}) && (fb == '0);
      a_nan    = (ea == {EXP_W{1'b1}}) && (fa != '0);
      b_nan    = (eb == {EXP_W{1'b1}}) && (fb != '0);
      spec_hit = 1'b1;
      spec_res = '0;
      spec_flg = '0;
      if (a_nan || b_nan) begin
         spec_res = QNAN;
      end else if (a_inf && b_inf) begin
         if (sa != sb) begin
            spec_res = QNAN;
            spec_flg = 4'b1000;
         end else begin
            spec_res = {sa, ea, fa};
         end
      end else if (a_inf) begin
         spec_res = {sa, ea, fa};
      end else if (b_inf) begin
         spec_res = {sb, eb, fb};
      end else if (a_zero && b_zero) begin
         spec_res = {sa & sb, {(W-1){1'b0}}};
      end else if (a_zero) begin
         spec_res = {sb, eb, fb};
      end else if (b_zero) begin
         spec_res = {sa, ea, fa};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Order operands by magnitude and right-shift the smaller one, folding lost bits into sticky.
   always_comb begin
      a_bigger = ({ea, fa} >= {eb, fb});
      big_s    = a_bigger ? sa : sb;
      big_e    = a_bigger ? ea : eb;
      big_f    = a_bigger ? fa : fb;
      sml_e    = a_bigger ? eb : ea;
      sml_f    = a_bigger ? fb : fa;
      diff     = big_e - sml_e;
      sml_m    = {1'b1, sml_f, 3'b000};
      sticky   = 1'b0;
      for (int i = 0; i < XW; i++) begin
         if (i < int'(diff)) sticky = sticky | sml_m[i];
      end
      al_m = (sml_m >> diff) | {{(XW-1){1'b0}}, sticky};
   end

   // Magnitude add or subtract; the larger operand is always on the left so no borrow out.
   always_comb begin
      add_sum = eff_sub ? ({1'b0, xm} - {1'b0, ym}) : ({1'b0, xm} + {1'b0, ym});
   end

   // Round-to-nearest-even on the normalised mantissa, renormalising if the increment carries out.
   always_comb begin
      rnd_inc = xm[2] & (xm[1] | xm[0] | xm[3]);
      inexact = xm[2] | xm[1] | xm[0];
      rnd_sum = {1'b0, xm[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
      if (rnd_sum[MAN_W+1]) begin
         rnd_m = rnd_sum[MAN_W+1:1];
         rnd_e = xe + ONE;
      end else begin
         rnd_m = rnd_sum[MAN_W:0];
         rnd_e = xe;
      end
   end

   // Sequencer and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         res_r <= '0;
         flg_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sa    <= bus.a[W-1];
                  ea    <= bus.a[W-2:MAN_W];
                  fa    <= bus.a[MAN_W-1:0];
                  sb    <= bus.b[W-1] ^ bus.op_sub;
                  eb    <= bus.b[W-2:MAN_W];
                  fb    <= bus.b[MAN_W-1:0];
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (spec_hit) begin
                  res_r <= spec_res;
                  flg_r <= spec_flg;
                  state <= OUT;
               end else begin
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               xs      <= big_s;
               xe      <= {2'b00, big_e};
               xm      <= {1'b1, big_f, 3'b000};
               ym      <= al_m;
               eff_sub <= sa ^ sb;
               state   <= ADD;
            end
            ADD: begin
               if (add_sum == '0) begin
                  res_r <= '0;
                  flg_r <= '0;
                  state <= OUT;
               end else if (add_sum[XW]) begin
                  xm    <= {add_sum[XW:2], add_sum[1] | add_sum[0]};
                  xe    <= xe + ONE;
                  state <= NORM;
               end else begin
                  xm    <= add_sum[XW-1:0];
                  state <= NORM;
               end
            end
            NORM: begin
               if (!xm[XW-1] && (xe > ONE)) begin
                  xm <= {xm[XW-2:0], 1'b0};
                  xe <= xe - ONE;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               if (rnd_e >= EXP_ONES) begin
                  res_r <= {xs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  flg_r <= 4'b0101;
               end else if (!rnd_m[MAN_W]) begin
                  res_r <= {xs, {(W-1){1'b0}}};
                  flg_r <= 4'b0011;
               end else begin
                  res_r <= {xs, rnd_e[EXP_W-1:0], rnd_m[MAN_W-1:0]};
                  flg_r <= {3'b000, inexact};
               end
               state <= OUT;
            end
            OUT: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single precision and half precision instances.
// Stimulus pushes hand-computed expectations, and per-instance monitors pop them on each result handshake.
module tb_fp_addsub_seq;
   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          acc;
      int          lat;
      string       name;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sq[$];
   exp_t hq[$];
   bit   s_seen = 0;
   bit   h_seen = 0;
   int   s_first = 0;
   int   h_first = 0;

   fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) ifs ();
   fp_addsub_seq_if #(.EXP_W(5), .MAN_W(10)) ifh ();

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs)
   );

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk   (clk),
      .reset (reset),
      .bus   (ifh)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input bit half, input logic [31:0] a, input logic [31:0] b,
                                input bit op, input logic [31:0] res, input logic [3:0] flg,
                                input int lat, input string name, input bit push);
      int   n;
      exp_t e;
      n = 0;
      while (!(half ? ifh.in_ready : ifs.in_ready) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_accept_timeout: got in_ready 0 expected 1", name);
         return;
      end
      if (half) begin
         ifh.a = a[15:0];
         ifh.b = b[15:0];
         ifh.op_sub = op;
         ifh.in_valid = 1'b1;
      end else begin
         ifs.a = a;
         ifs.b = b;
         ifs.op_sub = op;
         ifs.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      ifs.in_valid = 1'b0;
      ifh.in_valid = 1'b0;
      e.res  = res;
      e.flg  = flg;
      e.acc  = cyc;
      e.lat  = lat;
      e.name = name;
      if (push) begin
         if (half) hq.push_back(e);
         else sq.push_back(e);
      end
   endtask

   // Single-precision result monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         s_seen = 0;
      end else if (ifs.out_valid) begin
         if (!s_seen) begin
            s_seen  = 1;
            s_first = cyc;
         end
         if (ifs.out_ready) begin
            s_seen = 0;
            if (sq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL sp_stray_result: got %h expected no result", ifs.result);
            end else begin
               e = sq.pop_front();
               checkOutput({e.name, "_result"}, ifs.result, e.res);
               checkOutput({e.name, "_flags"}, 32'(ifs.flags), 32'(e.flg));
               if (e.lat >= 0) checkOutput({e.name, "_latency"}, 32'(s_first - e.acc), 32'(e.lat));
            end
         end
      end
   end

   // Half-precision result monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         h_seen = 0;
      end else if (ifh.out_valid) begin
         if (!h_seen) begin
            h_seen  = 1;
            h_first = cyc;
         end
         if (ifh.out_ready) begin
            h_seen = 0;
            if (hq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL hp_stray_result: got %h expected no result", ifh.result);
            end else begin
               e = hq.pop_front();
               checkOutput({e.name, "_result"}, 32'(ifh.result), e.res);
               checkOutput({e.name, "_flags"}, 32'(ifh.flags), 32'(e.flg));
               if (e.lat >= 0) checkOutput({e.name, "_latency"}, 32'(h_first - e.acc), 32'(e.lat));
            end
         end
      end
   end

   // Directed stimulus sequence
   initial begin
      int n;
      reset = 1'b1;
      ifs.in_valid = 1'b0; ifs.op_sub = 1'b0; ifs.a = '0; ifs.b = '0; ifs.out_ready = 1'b1;
      ifh.in_valid = 1'b0; ifh.op_sub = 1'b0; ifh.a = '0; ifh.b = '0; ifh.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(ifs.out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(ifs.in_ready), 32'd1);
      checkOutput("rst_result", ifs.result, 32'h0);
      checkOutput("rst_flags", 32'(ifs.flags), 32'h0);
      checkOutput("rst_hp_in_ready", 32'(ifh.in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      applyStimulus(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'h0, 5, "one_plus_two", 1);
      applyStimulus(0, 32'h3F800000, 32'h3F7FFFFF, 1, 32'h33800000, 4'h0, -1, "deep_cancel", 1);
      applyStimulus(0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'h0, -1, "exact_cancel", 1);
      applyStimulus(0, 32'h3FC00000, 32'h3F800000, 1, 32'h3F000000, 4'h0, 6, "norm_k1", 1);
      applyStimulus(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'h1, -1, "tie_even_down", 1);
      applyStimulus(0, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 4'h1, -1, "tie_odd_up", 1);
      applyStimulus(0, 32'h3FFFFFFF, 32'h33800000, 0, 32'h40000000, 4'h1, -1, "round_carry", 1);
      applyStimulus(0, 32'h3F800000, 32'h0D800000, 0, 32'h3F800000, 4'h1, -1, "far_sticky", 1);
      applyStimulus(0, 32'hBF800000, 32'hC0000000, 0, 32'hC0400000, 4'h0, -1, "neg_add", 1);
      applyStimulus(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 4'h8, -1, "inf_minus_inf", 1);
      applyStimulus(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'h5, -1, "overflow", 1);
      applyStimulus(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'h0, -1, "neg_zeros", 1);
      applyStimulus(0, 32'h00000000, 32'h00000000, 1, 32'h00000000, 4'h0, -1, "zero_sub_zero", 1);
      applyStimulus(0, 32'h00000000, 32'hC0000000, 0, 32'hC0000000, 4'h0, -1, "zero_operand", 1);
      applyStimulus(0, 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 4'h0, -1, "nan_in", 1);
      applyStimulus(0, 32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 4'h0, -1, "inf_plus_one", 1);
      applyStimulus(0, 32'h00000001, 32'h3F800000, 0, 32'h3F800000, 4'h0, -1, "denorm_flush", 1);
      applyStimulus(0, 32'h00800001, 32'h00800000, 1, 32'h00000000, 4'h3, -1, "underflow", 1);

      applyStimulus(1, 32'h3C00, 32'h3C00, 0, 32'h4000, 4'h0, 5, "hp_one_plus_one", 1);
      applyStimulus(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 4'h5, -1, "hp_overflow", 1);
      applyStimulus(1, 32'h3C00, 32'h3C00, 1, 32'h0000, 4'h0, -1, "hp_cancel", 1);

      // Back-pressure: the result must hold while the consumer stalls
      ifs.out_ready = 1'b0;
      applyStimulus(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'h0, 5, "stall", 1);
      n = 0;
      while (!ifs.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL stall_wait_valid: got out_valid 0 expected 1");
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_result", ifs.result, 32'h40400000);
         checkOutput("stall_valid", 32'(ifs.out_valid), 32'd1);
         checkOutput("stall_in_ready", 32'(ifs.in_ready), 32'd0);
      end
      ifs.out_ready = 1'b1;

      // Reset while normalising must drop the operation without any output
      applyStimulus(0, 32'h3F800000, 32'h3F7FFFFF, 1, 32'h0, 4'h0, -1, "abort", 0);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_out_valid", 32'(ifs.out_valid), 32'd0);
      checkOutput("abort_in_ready", 32'(ifs.in_ready), 32'd1);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("abort_no_result", 32'(ifs.out_valid), 32'd0);

      applyStimulus(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 4'h0, 5, "after_abort", 1);

      n = 0;
      while ((sq.size() != 0 || hq.size() != 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("sp_queue_drained", 32'(sq.size()), 32'd0);
      checkOutput("hp_queue_drained", 32'(hq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
